// File: rtl/mem_bus_arbiter_pkg.sv
// Shared bus encodings and arbiter-owner types for the processor-memory port.
// The cache controllers, the arbiter and its tag owner table all import this package.
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'h0,
    BUS_LOAD  = 2'h1,
    BUS_STORE = 2'h2
  } BUS_COMMAND;

  typedef enum logic [1:0] {
    BYTE   = 2'h0,
    HALF   = 2'h1,
    WORD   = 2'h2,
    DOUBLE = 2'h3
  } MEM_SIZE;

  typedef enum logic {
    ARB_ICACHE = 1'b0,
    ARB_DCACHE = 1'b1
  } ARB_OWNER;

  localparam int ARB_STARVE_LIMIT = 4;

  // The I-cache may only load; the D-cache may load or store.
  function automatic logic is_request(input logic [1:0] cmd, input logic allow_store);
    return (cmd == BUS_LOAD) || (allow_store && (cmd == BUS_STORE));
  endfunction

endpackage

// File: rtl/mem_tag_owner_table.sv
// Remembers which cache owns each outstanding memory load tag.
// Flags returns of unowned tags and allocations that clobber a live entry.
module mem_tag_owner_table
  import mem_bus_arbiter_pkg::*;
#(
  parameter int NUM_TAGS = 16
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        alloc_en_i,
  input  logic [$clog2(NUM_TAGS)-1:0] alloc_tag_i,
  input  ARB_OWNER                    alloc_owner_i,
  input  logic [$clog2(NUM_TAGS)-1:0] lookup_tag_i,
  output logic                        lookup_hit_o,
  output ARB_OWNER                    lookup_owner_o,
  output logic                        tag_error_o
);

  localparam int TAG_W = $clog2(NUM_TAGS);

  logic [NUM_TAGS-1:0] valid_q, valid_d;
  ARB_OWNER            owner_q [NUM_TAGS];
  ARB_OWNER            owner_d [NUM_TAGS];
  logic                error_q, error_d;
  logic                lookup_req;
  logic                clear_en;
  logic                alloc_clobber;

  assign lookup_req     = (lookup_tag_i != '0);
  assign lookup_hit_o   = lookup_req && valid_q[lookup_tag_i];
  assign lookup_owner_o = owner_q[lookup_tag_i];
  assign clear_en       = lookup_hit_o;
  assign tag_error_o    = error_q;

  // An entry freed by a return in the same cycle is not a clobber.
  assign alloc_clobber = alloc_en_i && valid_q[alloc_tag_i] &&
                         !(clear_en && (lookup_tag_i == alloc_tag_i));

  assign error_d = error_q || alloc_clobber || (lookup_req && !valid_q[lookup_tag_i]);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_TAGS; gi++) begin : g_entry
      logic alloc_here;
      logic clear_here;
      assign alloc_here   = alloc_en_i && (alloc_tag_i == TAG_W'(gi));
      assign clear_here   = clear_en && (lookup_tag_i == TAG_W'(gi));
      // Allocation takes precedence over a same-index clear.
      assign valid_d[gi]  = alloc_here ? 1'b1 : (clear_here ? 1'b0 : valid_q[gi]);
      assign owner_d[gi]  = alloc_here ? alloc_owner_i : owner_q[gi];
    end
  endgenerate

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      error_q <= 1'b0;
      for (int i = 0; i < NUM_TAGS; i++) owner_q[i] <= ARB_ICACHE;
    end else begin
      valid_q <= valid_d;
      error_q <= error_d;
      for (int i = 0; i < NUM_TAGS; i++) owner_q[i] <= owner_d[i];
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the processor-memory port between the I-cache and D-cache, holding a grant
// across memory retries and steering tagged load returns back to their owner.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int NUM_TAGS     = 16,
  parameter int STARVE_LIMIT = ARB_STARVE_LIMIT
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [1:0]      icache2arb_command,
  input  logic [XLEN-1:0] icache2arb_addr,
  output logic [3:0]      arb2icache_response,
  output logic [3:0]      arb2icache_tag,
  output logic [63:0]     arb2icache_data,
  input  logic [1:0]      dcache2arb_command,
  input  logic [XLEN-1:0] dcache2arb_addr,
  input  logic [63:0]     dcache2arb_data,
  input  logic [1:0]      dcache2arb_size,
  output logic [3:0]      arb2dcache_response,
  output logic [3:0]      arb2dcache_tag,
  output logic [63:0]     arb2dcache_data,
  output logic [1:0]      proc2mem_command,
  output logic [XLEN-1:0] proc2mem_addr,
  output logic [63:0]     proc2mem_data,
  output logic [1:0]      proc2mem_size,
  input  logic [3:0]      mem2proc_response,
  input  logic [63:0]     mem2proc_data,
  input  logic [3:0]      mem2proc_tag,
  output logic            arb_grant_dcache,
  output logic            arb_tag_error
);

  localparam int                CNT_W      = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0]  STARVE_MAX = CNT_W'(STARVE_LIMIT);

  logic             icache_req, dcache_req;
  logic             locked_active;
  logic             grant_valid;
  ARB_OWNER         grant_owner;
  logic [1:0]       grant_cmd;
  logic             accepted;
  logic             alloc_en;
  logic             lookup_hit;
  ARB_OWNER         lookup_owner;

  logic             lock_valid_q, lock_valid_d;
  ARB_OWNER         lock_owner_q, lock_owner_d;
  logic [CNT_W-1:0] starve_q, starve_d;

  assign icache_req = is_request(icache2arb_command, 1'b0);
  assign dcache_req = is_request(dcache2arb_command, 1'b1);

  always_comb begin
    grant_valid   = 1'b0;
    grant_owner   = ARB_ICACHE;
    locked_active = lock_valid_q &&
                    ((lock_owner_q == ARB_DCACHE) ? dcache_req : icache_req);
    if (locked_active) begin
      grant_valid = 1'b1;
      grant_owner = lock_owner_q;
    end else if (icache_req && (starve_q == STARVE_MAX)) begin
      grant_valid = 1'b1;
      grant_owner = ARB_ICACHE;
    end else if (dcache_req) begin
      grant_valid = 1'b1;
      grant_owner = ARB_DCACHE;
    end else if (icache_req) begin
      grant_valid = 1'b1;
      grant_owner = ARB_ICACHE;
    end
  end

  assign grant_cmd = (grant_owner == ARB_DCACHE) ? dcache2arb_command : BUS_LOAD;
  assign accepted  = grant_valid && (mem2proc_response != '0);
  assign alloc_en  = accepted && (grant_cmd == BUS_LOAD);

  mem_tag_owner_table #(
    .NUM_TAGS (NUM_TAGS)
  ) u_owner_table (
    .clock          (clock),
    .reset          (reset),
    .alloc_en_i     (alloc_en),
    .alloc_tag_i    (mem2proc_response),
    .alloc_owner_i  (grant_owner),
    .lookup_tag_i   (mem2proc_tag),
    .lookup_hit_o   (lookup_hit),
    .lookup_owner_o (lookup_owner),
    .tag_error_o    (arb_tag_error)
  );

  // Everything combinational is held quiet while reset is asserted.
  always_comb begin
    proc2mem_command    = BUS_NONE;
    proc2mem_addr       = '0;
    proc2mem_data       = '0;
    proc2mem_size       = BYTE;
    arb2icache_response = '0;
    arb2dcache_response = '0;
    arb2icache_tag      = '0;
    arb2dcache_tag      = '0;
    arb2icache_data     = '0;
    arb2dcache_data     = '0;
    arb_grant_dcache    = 1'b0;
    if (reset) begin
      arb2icache_data = mem2proc_data;
      arb2dcache_data = mem2proc_data;
      if (grant_valid) begin
        if (grant_owner == ARB_DCACHE) begin
          proc2mem_command    = dcache2arb_command;
          proc2mem_addr       = dcache2arb_addr;
          proc2mem_data       = dcache2arb_data;
          proc2mem_size       = dcache2arb_size;
          arb2dcache_response = mem2proc_response;
          arb_grant_dcache    = 1'b1;
        end else begin
          proc2mem_command    = BUS_LOAD;
          proc2mem_addr       = icache2arb_addr;
          proc2mem_size       = DOUBLE;
          arb2icache_response = mem2proc_response;
        end
      end
      if (lookup_hit) begin
        if (lookup_owner == ARB_DCACHE) arb2dcache_tag = mem2proc_tag;
        else                            arb2icache_tag = mem2proc_tag;
      end
    end
  end

  always_comb begin
    lock_valid_d = grant_valid && (mem2proc_response == '0);
    lock_owner_d = grant_valid ? grant_owner : lock_owner_q;
    if (!icache_req || (accepted && (grant_owner == ARB_ICACHE))) begin
      starve_d = '0;
    end else if (starve_q != STARVE_MAX) begin
      starve_d = starve_q + 1'b1;
    end else begin
      starve_d = starve_q;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lock_valid_q <= 1'b0;
      lock_owner_q <= ARB_ICACHE;
      starve_q     <= '0;
    end else begin
      lock_valid_q <= lock_valid_d;
      lock_owner_q <= lock_owner_d;
      starve_q     <= starve_d;
    end
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single processor-memory port (proc2mem_* / mem2proc_*) between the I-cache (loads only) and the D-cache (loads and stores, including victim writebacks).
- Selects one requester per cycle and holds that grant across memory retries.
- Records which requester owns each outstanding load tag, and routes tagged returns back to that owner.
- Sits between the cache controllers and the processor's memory-side outputs.

Parameters:
- XLEN, 32, address width.
- NUM_TAGS, 16, tag space size; tag 0 means "none".
- STARVE_LIMIT, 4, number of consecutive denied I-cache request cycles before the I-cache is forced to win.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- icache2arb_command  in  2  BUS_NONE/BUS_LOAD; any BUS_STORE is treated as BUS_NONE
- icache2arb_addr  in  XLEN  load address
- arb2icache_response  out  4  memory response tag when the I-cache is granted, else 0
- arb2icache_tag  out  4  returning tag if owned by the I-cache, else 0
- arb2icache_data  out  64  mem2proc_data passthrough
- dcache2arb_command  in  2  BUS_NONE/BUS_LOAD/BUS_STORE
- dcache2arb_addr  in  XLEN  address
- dcache2arb_data  in  64  store data
- dcache2arb_size  in  2  BYTE/HALF/WORD/DOUBLE
- arb2dcache_response  out  4  memory response tag when the D-cache is granted, else 0
- arb2dcache_tag  out  4  returning tag if owned by the D-cache, else 0
- arb2dcache_data  out  64  mem2proc_data passthrough
- proc2mem_command  out  2  to memory
- proc2mem_addr  out  XLEN  to memory
- proc2mem_data  out  64  to memory
- proc2mem_size  out  2  to memory
- mem2proc_response  in  4  acceptance tag; 0 means retry
- mem2proc_data  in  64  returned data
- mem2proc_tag  in  4  returning tag; 0 means none
- arb_grant_dcache  out  1  debug: 1 when the D-cache holds the grant this cycle
- arb_tag_error  out  1  sticky: set when an unowned tag returns

Behaviour:
- Reset (reset==0, async):
  - Owner table cleared: all entries invalid.
  - starve_cnt=0, lock_valid=0, arb_tag_error=0.
  - All combinational outputs forced to 0 / BUS_NONE while reset is low.
- Grant selection (combinational), evaluated in this priority order:
  1. If lock_valid and the locked requester's command is not NONE, grant the locked requester.
  2. Otherwise, if the I-cache requests and starve_cnt==STARVE_LIMIT, grant the I-cache.
  3. Otherwise, if the D-cache requests, grant the D-cache.
  4. Otherwise, if the I-cache requests, grant the I-cache.
  5. Otherwise, no grant.
- Outputs to memory:
  - proc2mem_* mirrors the granted requester's signals in the same cycle.
  - An I-cache grant drives size=DOUBLE and data=0.
  - No grant drives command=BUS_NONE and addr/data=0.
- Acceptance:
  - mem2proc_response is forwarded the same cycle to the granted requester only.
  - The other requester sees response 0.
- Lock register (updated at posedge):
  - Granted, command!=NONE, response==0: lock_valid=1, lock_owner=granted requester.
  - Response!=0, or the locked requester dropped its command: lock_valid=0.
- Starvation counter:
  - Increments (saturating at STARVE_LIMIT) each cycle the I-cache requests but is not accepted.
  - Clears when an I-cache request is accepted, or when the I-cache is not requesting.
- Owner table, NUM_TAGS entries of {valid, owner}:
  - Allocate on an accepted BUS_LOAD: entry[response] = {1, grantee}.
  - Stores allocate nothing.
  - On mem2proc_tag!=0 with a valid entry: route the tag to its owner (the other requester sees 0), then clear the entry at posedge.
  - Same index allocated and cleared in one cycle: allocation wins and the entry stays valid.
  - Allocation onto an already-valid entry overwrites it and sets arb_tag_error.
- Tag error:
  - mem2proc_tag!=0 with an invalid entry: both tag outputs are 0, data is dropped, arb_tag_error is set.
  - arb_tag_error is cleared only by reset.
- Latency: zero-cycle combinational path for both request and return; state changes only at posedge.
- Reset mid-transaction: in-flight tags are forgotten; a later return of such a tag sets arb_tag_error.

Decomposition:
- Shared package (existing sys_defs):
  - BUS_COMMAND enum (BUS_NONE/BUS_LOAD/BUS_STORE) and MEM_SIZE enum.
  - New typedef ARB_OWNER {ARB_ICACHE, ARB_DCACHE}.
  - New constant ARB_STARVE_LIMIT.
- One sub-module, mem_tag_owner_table:
  - Allocate port and lookup/clear port.
  - Valid bits, owner bits and error flag.

Test Plan:
- Reset with reset=0 while both caches request → proc2mem_command=BUS_NONE, both responses 0. Release reset, D-cache LOAD 0x100 with response=3 → D-cache wins, arb2dcache_response=3, entry 3 owned by D-cache.
- Both request, memory responds 0 for 2 cycles then 5 → D-cache keeps the grant all 3 cycles (lock). I-cache is forced in the 5th contended cycle (starve_cnt reaches 4 after 4 denied cycles).
- I-cache LOAD accepted with tag 7; later mem2proc_tag=7 with data 0xDEADBEEF → arb2icache_tag=7, arb2dcache_tag=0, entry 7 cleared.
- D-cache STORE accepted with tag 2, then mem2proc_tag=2 → no allocation was made, so arb_tag_error=1 and both tag outputs are 0.
- Tag 4 returns to the I-cache in the same cycle a D-cache load is accepted with tag 4 → I-cache receives 4; entry 4 remains valid with owner D-cache.
- I-cache locked after a retry, then drops its request → lock releases the next cycle and the waiting D-cache is granted.
